// File: rtl/interleave_observer.sv
// Observe-side recorder: per accepted stimulus write, captures the pre-write vector,
// the first vector that settles to the expected value (or the timeout value), and the latency.
module interleave_observer #(
  parameter int WIDTH      = 8,
  parameter int SETTLE_MAX = 15,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] obs,
  input  logic [WIDTH-1:0] exp,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [WIDTH-1:0] rec_before,
  output logic [WIDTH-1:0] rec_after,
  output logic [CNT_W-1:0] rec_latency,
  output logic             rec_timeout,
  output logic             busy,
  output logic             stim_drop,
  output logic [7:0]       drop_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, REPORT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] before_q;
  logic [CNT_W-1:0] cnt;
  logic             drop;

  // A stimulus is rejected whenever a capture is still open and cannot retire this cycle.
  assign drop = stim_valid && ((state == SETTLE) || ((state == REPORT) && !rec_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      exp_q       <= '0;
      before_q    <= '0;
      cnt         <= '0;
      rec_valid   <= 1'b0;
      rec_before  <= '0;
      rec_after   <= '0;
      rec_latency <= '0;
      rec_timeout <= 1'b0;
      busy        <= 1'b0;
      stim_drop   <= 1'b0;
      drop_count  <= '0;
    end else begin
      stim_drop <= drop;
      if (drop && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;

      case (state)
        IDLE: begin
          if (stim_valid) begin
            before_q <= obs;
            exp_q    <= exp;
            cnt      <= CNT_ONE;
            state    <= SETTLE;
            busy     <= 1'b1;
          end
        end

        SETTLE: begin
          // Case equality so an x/z bit only matches an identical x/z bit in simulation.
          if (obs === exp_q) begin
            rec_before  <= before_q;
            rec_after   <= obs;
            rec_latency <= cnt;
            rec_timeout <= 1'b0;
            rec_valid   <= 1'b1;
            state       <= REPORT;
          end else if (cnt == CNT_MAX) begin
            rec_before  <= before_q;
            rec_after   <= obs;
            rec_latency <= CNT_MAX;
            rec_timeout <= 1'b1;
            rec_valid   <= 1'b1;
            state       <= REPORT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        REPORT: begin
          if (rec_ready) begin
            rec_valid <= 1'b0;
            if (stim_valid) begin
              before_q <= obs;
              exp_q    <= exp;
              cnt      <= CNT_ONE;
              state    <= SETTLE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interleave_observer.sv
// Directed bench for interleave_observer: capture/settle/timeout, backpressure, drops, reset.
module tb_interleave_observer;

  logic       clk = 1'b0;
  logic       rst;
  logic       stim_valid;
  logic [7:0] obs;
  logic [7:0] exp;
  logic       rec_valid;
  logic       rec_ready;
  logic [7:0] rec_before;
  logic [7:0] rec_after;
  logic [3:0] rec_latency;
  logic       rec_timeout;
  logic       busy;
  logic       stim_drop;
  logic [7:0] drop_count;

  int total = 0;
  int bad   = 0;
  int seen_valid;
  logic [7:0] xval;

  always #5 clk = ~clk;

  interleave_observer #(.WIDTH(8), .SETTLE_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stim_valid(stim_valid), .obs(obs), .exp(exp),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_before(rec_before),
    .rec_after(rec_after), .rec_latency(rec_latency), .rec_timeout(rec_timeout),
    .busy(busy), .stim_drop(stim_drop), .drop_count(drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    xval = 8'bxxxxxxxx;
    rst = 1'b1; stim_valid = 1'b0; rec_ready = 1'b0; obs = 8'h00; exp = 8'h00;
    tick(); tick();
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    chk("rst_latency", 32'(rec_latency), 32'd0);
    rst = 1'b0;
    tick();

    // 1: obs unknown at the write, settles to 5A three cycles later
    stim_valid = 1'b1; obs = xval; exp = 8'h5A;
    tick();
    stim_valid = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_early_valid", 32'(rec_valid), 32'd0);
    tick(); tick();
    obs = 8'h5A;
    tick();
    chk("t1_valid", 32'(rec_valid), 32'd1);
    chk("t1_before", 32'(rec_before), 32'(xval));
    chk("t1_after", 32'(rec_after), 32'h5A);
    chk("t1_latency", 32'(rec_latency), 32'd3);
    chk("t1_timeout", 32'(rec_timeout), 32'd0);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    chk("t1_retired", 32'(rec_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: already matching in first settle cycle
    stim_valid = 1'b1; obs = 8'h5A; exp = 8'h5A;
    tick();
    stim_valid = 1'b0;
    chk("t2_not_yet", 32'(rec_valid), 32'd0);
    tick();
    chk("t2_valid", 32'(rec_valid), 32'd1);
    chk("t2_latency", 32'(rec_latency), 32'd1);
    chk("t2_after", 32'(rec_after), 32'h5A);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;

    // 3: stuck at 00 while expecting FF -> timeout after 15
    stim_valid = 1'b1; obs = 8'h00; exp = 8'hFF;
    tick();
    stim_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("t3_not_yet", 32'(rec_valid), 32'd0);
    tick();
    chk("t3_valid", 32'(rec_valid), 32'd1);
    chk("t3_timeout", 32'(rec_timeout), 32'd1);
    chk("t3_latency", 32'(rec_latency), 32'd15);
    chk("t3_after", 32'(rec_after), 32'h00);

    // 4: backpressure for 5 cycles, a stim during REPORT is dropped
    obs = 8'h33; stim_valid = 1'b1; exp = 8'hAA;
    tick();
    stim_valid = 1'b0;
    chk("t4_drop_pulse", 32'(stim_drop), 32'd1);
    chk("t4_drop_count", 32'(drop_count), 32'd1);
    tick();
    chk("t4_drop_end", 32'(stim_drop), 32'd0);
    tick(); tick(); tick();
    chk("t4_hold_valid", 32'(rec_valid), 32'd1);
    chk("t4_hold_after", 32'(rec_after), 32'h00);
    chk("t4_hold_latency", 32'(rec_latency), 32'd15);
    chk("t4_hold_timeout", 32'(rec_timeout), 32'd1);
    rec_ready = 1'b1; stim_valid = 1'b1; obs = 8'h44; exp = 8'h44;
    tick();
    rec_ready = 1'b0; stim_valid = 1'b0;
    chk("t4_handoff_valid", 32'(rec_valid), 32'd0);
    chk("t4_handoff_busy", 32'(busy), 32'd1);
    chk("t4_handoff_nodrop", 32'(stim_drop), 32'd0);
    chk("t4_handoff_count", 32'(drop_count), 32'd1);
    tick();
    chk("t4_new_valid", 32'(rec_valid), 32'd1);
    chk("t4_new_before", 32'(rec_before), 32'h44);
    chk("t4_new_latency", 32'(rec_latency), 32'd1);
    chk("t4_new_timeout", 32'(rec_timeout), 32'd0);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;

    // 5: reset in the middle of a settle window
    stim_valid = 1'b1; obs = 8'h00; exp = 8'hFF;
    tick();
    stim_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_before", 32'(rec_before), 32'd0);
    chk("t5_latency", 32'(rec_latency), 32'd0);
    chk("t5_drops", 32'(drop_count), 32'd0);
    tick();
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rec_valid) seen_valid++;
    end
    chk("t5_no_record", 32'(seen_valid), 32'd0);

    // continuous stim while a capture is open -> saturating drop counter
    stim_valid = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("t5_drops_10", 32'(drop_count), 32'd10);
    for (int i = 0; i < 290; i++) tick();
    chk("t5_drops_sat", 32'(drop_count), 32'd255);
    chk("t5_drop_pulse", 32'(stim_drop), 32'd1);
    stim_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
